// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller: FSM encoding, Mem field layout,
// watchdog default and the load-use detection rule.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    localparam int MEM_READ_BIT  = 1;
    localparam int MEM_WRITE_BIT = 0;

    localparam int unsigned STALL_LIMIT_DEFAULT = 1023;

    // A load in ID/EX feeding a register the IF/ID instruction reads; x0 never hazards.
    function automatic logic is_load_use(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic       use_rs1,
        input logic [4:0] rs2,
        input logic       use_rs2
    );
        return mem_read && (rd != 5'd0) &&
               ((use_rs1 && (rd == rs1)) || (use_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-facing signal bundle of the hazard controller. The pipeline side uses
// the master modport, the controller the slave modport.
interface hazard_controller_if;

    logic       ICache_stall;
    logic       DCache_stall;
    logic [4:0] Rs1_1;
    logic [4:0] Rs2_1;
    logic       use_rs1_1;
    logic       use_rs2_1;
    logic [4:0] Rd_2;
    logic [1:0] Mem_2;
    logic       redirect_3;

    logic       memory_stall;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_flush;
    logic       idex_bubble;
    logic       stall_timeout;

    modport master (
        output ICache_stall, DCache_stall, Rs1_1, Rs2_1, use_rs1_1, use_rs2_1,
               Rd_2, Mem_2, redirect_3,
        input  memory_stall, pc_write, ifid_write, ifid_flush, idex_flush,
               idex_bubble, stall_timeout
    );

    modport slave (
        input  ICache_stall, DCache_stall, Rs1_1, Rs2_1, use_rs1_1, use_rs2_1,
               Rd_2, Mem_2, redirect_3,
        output memory_stall, pc_write, ifid_write, ifid_flush, idex_flush,
               idex_bubble, stall_timeout
    );

endinterface

// File: rtl/hazard_controller_stall_watchdog.sv
// Saturating counter of consecutive memory-stall cycles with a sticky timeout
// flag that holds until reset.
module stall_watchdog
    import hazard_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = STALL_LIMIT_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      stall_i,
    input  hz_state_e state_i,
    output logic      stall_timeout
);

    localparam int CW = $clog2(STALL_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STALL_LIMIT);

    logic [CW-1:0] count_q, count_d;
    logic          timeout_q, timeout_d;

    // A stall seen while still in RUN starts a fresh episode at one.
    always_comb begin
        count_d = '0;
        if (stall_i) begin
            if (state_i == RUN) begin
                count_d = CW'(1);
            end else if (count_q == LIMIT) begin
                count_d = count_q;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
        timeout_d = timeout_q | (count_d == LIMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_timeout = timeout_q;

endmodule

// File: rtl/hazard_controller.sv
// Load-use, memory-stall and redirect-flush control for the five-stage core.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned STALL_LIMIT = STALL_LIMIT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    hazard_controller_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]         perf_stall_cycles,
    output logic [31:0]         perf_bubbles,
    output logic [31:0]         perf_flushes
`endif
);

    hz_state_e state_q, state_d;
    logic      flush_pend_q, flush_pend_d;
    logic      memory_stall, load_use, flush_req;
    logic      pc_write_c, ifid_write_c, flush_c, bubble_c;
    logic      unused_mem_write;

    assign unused_mem_write = hz.Mem_2[MEM_WRITE_BIT];

    // Output priority: memory stall, then flush, then load-use bubble.
    always_comb begin
        memory_stall = hz.ICache_stall | hz.DCache_stall;
        load_use     = is_load_use(hz.Mem_2[MEM_READ_BIT], hz.Rd_2,
                                   hz.Rs1_1, hz.use_rs1_1, hz.Rs2_1, hz.use_rs2_1);
        flush_req    = hz.redirect_3 | flush_pend_q;

        pc_write_c   = 1'b1;
        ifid_write_c = 1'b1;
        flush_c      = 1'b0;
        bubble_c     = 1'b0;
        if (memory_stall) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
        end else if (flush_req) begin
            flush_c      = 1'b1;
        end else if (load_use) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            bubble_c     = 1'b1;
        end

        flush_pend_d = memory_stall ? (flush_pend_q | hz.redirect_3) : 1'b0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (memory_stall)  state_d = MEM_WAIT;
            MEM_WAIT: if (!memory_stall) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    stall_watchdog #(
        .STALL_LIMIT (STALL_LIMIT)
    ) u_watchdog (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (memory_stall),
        .state_i       (state_q),
        .stall_timeout (hz.stall_timeout)
    );

    assign hz.memory_stall = memory_stall;
    assign hz.pc_write     = pc_write_c;
    assign hz.ifid_write   = ifid_write_c;
    assign hz.ifid_flush   = flush_c;
    assign hz.idex_flush   = flush_c;
    assign hz.idex_bubble  = bubble_c;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d  = perf_stall_q  + ((state_q == MEM_WAIT) ? 32'd1 : 32'd0);
        perf_bubble_d = perf_bubble_q + (bubble_c ? 32'd1 : 32'd0);
        perf_flush_d  = perf_flush_q  + (flush_c  ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q  <= '0;
            perf_bubble_q <= '0;
            perf_flush_q  <= '0;
        end else begin
            perf_stall_q  <= perf_stall_d;
            perf_bubble_q <= perf_bubble_d;
            perf_flush_q  <= perf_flush_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_bubbles      = perf_bubble_q;
    assign perf_flushes      = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: a spec-level model checked every cycle
// plus hand-computed literal checks. Perf counters checked when HAZARD_PERF_CNT_EN is set.
module tb_hazard_controller;

    localparam int unsigned LIMIT = 8;

    logic clk;
    logic rst;
    hazard_controller_if hz();

    int  n_compared   = 0;
    int  n_mismatched = 0;
    bit  check_on     = 1'b0;

    bit          mdl_held       = 1'b0;
    int unsigned mdl_run        = 0;
    bit          mdl_timeout    = 1'b0;
    bit          mdl_prev_stall = 1'b0;
    int unsigned mdl_perf_stall = 0;
    int unsigned mdl_perf_bub   = 0;
    int unsigned mdl_perf_flush = 0;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_bubbles, perf_flushes;
`endif

    hazard_controller #(.STALL_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_bubbles      (perf_bubbles),
        .perf_flushes      (perf_flushes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {memory_stall, pc_write, ifid_write, ifid_flush, idex_flush, idex_bubble}
    function automatic logic [5:0] expectVec(input bit held);
        bit stall, lu, flush;
        stall = hz.ICache_stall || hz.DCache_stall;
        lu    = hz.Mem_2[1] && (hz.Rd_2 != 0) &&
                ((hz.use_rs1_1 && hz.Rd_2 == hz.Rs1_1) ||
                 (hz.use_rs2_1 && hz.Rd_2 == hz.Rs2_1));
        flush = hz.redirect_3 || held;
        if (stall)      return 6'b100000;
        else if (flush) return 6'b011110;
        else if (lu)    return 6'b000001;
        else            return 6'b011000;
    endfunction

    // Reference model: remembered redirect, stall run length, sticky timeout, event totals.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mdl_held       <= 1'b0;
            mdl_run        <= 0;
            mdl_timeout    <= 1'b0;
            mdl_prev_stall <= 1'b0;
            mdl_perf_stall <= 0;
            mdl_perf_bub   <= 0;
            mdl_perf_flush <= 0;
        end else begin
            logic [5:0] e;
            bit stall;
            e     = expectVec(mdl_held);
            stall = hz.ICache_stall || hz.DCache_stall;
            if (mdl_prev_stall) mdl_perf_stall <= mdl_perf_stall + 1;
            if (e[0])           mdl_perf_bub   <= mdl_perf_bub + 1;
            if (e[2])           mdl_perf_flush <= mdl_perf_flush + 1;
            if (stall) begin
                mdl_held <= mdl_held || hz.redirect_3;
                mdl_run  <= (mdl_run < LIMIT) ? mdl_run + 1 : LIMIT;
                if (mdl_run + 1 >= LIMIT) mdl_timeout <= 1'b1;
            end else begin
                mdl_held <= 1'b0;
                mdl_run  <= 0;
            end
            mdl_prev_stall <= stall;
        end
    end

    // Per-cycle comparison of DUT outputs against the model, mid-cycle.
    initial forever begin
        @(negedge clk);
        if (check_on) begin
            logic [5:0] e, a;
            e = expectVec(mdl_held);
            a = {hz.memory_stall, hz.pc_write, hz.ifid_write,
                 hz.ifid_flush, hz.idex_flush, hz.idex_bubble};
            n_compared++;
            if (a !== e) begin
                n_mismatched++;
                $display("[TB] FAIL outputs t=%0t actual=%b required=%b", $time, a, e);
            end
            n_compared++;
            if (hz.stall_timeout !== mdl_timeout) begin
                n_mismatched++;
                $display("[TB] FAIL stall_timeout t=%0t actual=%b required=%b",
                         $time, hz.stall_timeout, mdl_timeout);
            end
`ifdef HAZARD_PERF_CNT_EN
            n_compared++;
            if (perf_stall_cycles !== mdl_perf_stall || perf_bubbles !== mdl_perf_bub ||
                perf_flushes !== mdl_perf_flush) begin
                n_mismatched++;
                $display("[TB] FAIL perf t=%0t actual=%0d/%0d/%0d required=%0d/%0d/%0d",
                         $time, perf_stall_cycles, perf_bubbles, perf_flushes,
                         mdl_perf_stall, mdl_perf_bub, mdl_perf_flush);
            end
`endif
        end
    end

    task automatic applyStimulus(input logic ic, input logic dc,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2,
                                 input logic [4:0] rd, input logic [1:0] mem,
                                 input logic redir);
        @(posedge clk);
        #1;
        hz.ICache_stall = ic;
        hz.DCache_stall = dc;
        hz.Rs1_1        = rs1;
        hz.Rs2_1        = rs2;
        hz.use_rs1_1    = u1;
        hz.use_rs2_1    = u2;
        hz.Rd_2         = rd;
        hz.Mem_2        = mem;
        hz.redirect_3   = redir;
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 2'b00, 0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        hz.ICache_stall = 0; hz.DCache_stall = 0;
        hz.Rs1_1 = 0; hz.Rs2_1 = 0; hz.use_rs1_1 = 0; hz.use_rs2_1 = 0;
        hz.Rd_2 = 0; hz.Mem_2 = 0; hz.redirect_3 = 0;

        @(negedge clk);
        checkOutput("reset_timeout", {31'd0, hz.stall_timeout}, 0);
        checkOutput("reset_pc_write", {31'd0, hz.pc_write}, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        check_on = 1'b1;
        $display("[TB] reset released");

        idle();
        checkOutput("idle_ifid_write", {31'd0, hz.ifid_write}, 1);

        applyStimulus(0, 0, 5'd5, 5'd0, 1, 0, 5'd5, 2'b10, 0);
        checkOutput("lu_bubble", {31'd0, hz.idex_bubble}, 1);
        checkOutput("lu_pc_write", {31'd0, hz.pc_write}, 0);
        checkOutput("lu_ifid_write", {31'd0, hz.ifid_write}, 0);
        applyStimulus(0, 0, 5'd5, 5'd0, 1, 0, 5'd5, 2'b00, 0);
        checkOutput("after_lu_bubble", {31'd0, hz.idex_bubble}, 0);
        checkOutput("after_lu_pc_write", {31'd0, hz.pc_write}, 1);

        applyStimulus(0, 0, 5'd0, 5'd0, 1, 0, 5'd0, 2'b10, 0);
        checkOutput("x0_bubble", {31'd0, hz.idex_bubble}, 0);
        applyStimulus(0, 0, 5'd3, 5'd7, 0, 1, 5'd7, 2'b10, 0);
        checkOutput("rs2_bubble", {31'd0, hz.idex_bubble}, 1);
        applyStimulus(0, 0, 5'd3, 5'd7, 0, 0, 5'd7, 2'b10, 0);
        checkOutput("unused_src_bubble", {31'd0, hz.idex_bubble}, 0);
        applyStimulus(0, 0, 5'd9, 5'd0, 1, 0, 5'd9, 2'b01, 0);
        checkOutput("store_bubble", {31'd0, hz.idex_bubble}, 0);
        idle();

        $display("[TB] redirect held across D-cache stall");
        applyStimulus(0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 2'b00, 1);
        checkOutput("held_no_flush", {31'd0, hz.ifid_flush}, 0);
        checkOutput("held_stall", {31'd0, hz.memory_stall}, 1);
        applyStimulus(0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 2'b00, 0);
        applyStimulus(0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 2'b00, 1);
        applyStimulus(0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 2'b00, 0);
        checkOutput("held_pc_write", {31'd0, hz.pc_write}, 0);
        idle();
        checkOutput("release_ifid_flush", {31'd0, hz.ifid_flush}, 1);
        checkOutput("release_idex_flush", {31'd0, hz.idex_flush}, 1);
        checkOutput("release_pc_write", {31'd0, hz.pc_write}, 1);
        idle();
        checkOutput("flush_once", {31'd0, hz.ifid_flush}, 0);

        applyStimulus(0, 0, 5'd5, 5'd0, 1, 0, 5'd5, 2'b10, 1);
        checkOutput("redir_vs_lu_flush", {31'd0, hz.idex_flush}, 1);
        checkOutput("redir_vs_lu_bubble", {31'd0, hz.idex_bubble}, 0);
        idle();

        $display("[TB] watchdog");
        for (int k = 1; k <= 8; k++) applyStimulus(1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 2'b00, 0);
        checkOutput("wd_before_limit", {31'd0, hz.stall_timeout}, 0);
        applyStimulus(1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 2'b00, 0);
        checkOutput("wd_at_limit", {31'd0, hz.stall_timeout}, 1);
        applyStimulus(1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 2'b00, 0);
        idle();
        checkOutput("wd_sticky", {31'd0, hz.stall_timeout}, 1);
        idle();

        $display("[TB] reset mid-stall");
        applyStimulus(0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 2'b00, 1);
        applyStimulus(0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 2'b00, 0);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        checkOutput("rst_clears_timeout", {31'd0, hz.stall_timeout}, 0);
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("rst_perf_stall", perf_stall_cycles, 0);
        checkOutput("rst_perf_bubbles", perf_bubbles, 0);
        checkOutput("rst_perf_flushes", perf_flushes, 0);
`endif
        idle();
        checkOutput("rst_drops_pending", {31'd0, hz.ifid_flush}, 0);
        idle();
        #2 rst = 1'b1;
        #2 rst = 1'b0;

        $display("[TB] perf sequence");
        for (int k = 0; k < 3; k++) applyStimulus(1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 2'b00, 0);
        idle();
        applyStimulus(0, 0, 5'd4, 5'd0, 1, 0, 5'd4, 2'b10, 0);
        idle();
        applyStimulus(0, 0, 5'd0, 5'd6, 0, 1, 5'd6, 2'b10, 0);
        idle();
        applyStimulus(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 2'b00, 1);
        idle();
        checkOutput("mdl_perf_stall", mdl_perf_stall, 3);
        checkOutput("mdl_perf_bubbles", mdl_perf_bub, 2);
        checkOutput("mdl_perf_flushes", mdl_perf_flush, 1);
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("perf_stall", perf_stall_cycles, 3);
        checkOutput("perf_bubbles", perf_bubbles, 2);
        checkOutput("perf_flushes", perf_flushes, 1);
`endif
        idle();
        check_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline control unit for the five-stage RISC-V core. It detects load-use hazards between the IF/ID and ID/EX instructions and merges I-cache and D-cache stalls into the global `memory_stall` that freezes every stage, including the execution stage. It also sequences branch/jump redirect flushes, holding any redirect that arrives during a memory stall until the stall releases. A watchdog flags runaway stalls.

## Interface
- `STALL_LIMIT`, default 1023: number of consecutive stall cycles after which `stall_timeout` sets; legal range 1..65535.
- `clk` input 1: core clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `ICache_stall` input 1: instruction fetch not ready.
- `DCache_stall` input 1: data access not ready.
- `Rs1_1`, `Rs2_1` input 5 each: source registers of the IF/ID instruction.
- `use_rs1_1`, `use_rs2_1` input 1 each: the IF/ID instruction actually reads that source.
- `Rd_2` input 5: destination of the ID/EX instruction.
- `Mem_2` input 2: ID/EX memory control, {MemRead, MemWrite}.
- `redirect_3` input 1: one-cycle pulse; branch taken or jump resolved in EX.
- `memory_stall` output 1: global freeze, equal to `ICache_stall | DCache_stall`.
- `pc_write` output 1: PC register update enable.
- `ifid_write` output 1: IF/ID register update enable.
- `ifid_flush` output 1: load a NOP into IF/ID.
- `idex_flush` output 1: load a NOP into ID/EX.
- `idex_bubble` output 1: load a NOP into ID/EX for a load-use bubble.
- `stall_timeout` output 1: sticky watchdog flag.

## Operation
- `load_use` = `Mem_2[1]` && `Rd_2` != 0 && ((`use_rs1_1` && `Rd_2` == `Rs1_1`) || (`use_rs2_1` && `Rd_2` == `Rs2_1`)).
- `flush_req` = `redirect_3` || `flush_pend`.
- The FSM has two states, RUN and MEM_WAIT.
  - RUN → MEM_WAIT when `memory_stall` = 1.
  - MEM_WAIT → RUN when `memory_stall` = 0.
- The outputs below follow the same rules in both states. The state drives only the watchdog and the performance counters.
- Output priority, highest first:
  1. **`memory_stall` = 1:** `pc_write` = `ifid_write` = 0; all flush and bubble outputs are 0.
  2. **`flush_req`:** `pc_write` = 1, `ifid_write` = 1, `ifid_flush` = `idex_flush` = 1, `idex_bubble` = 0. A redirect overrides a load-use hazard because the dependent instruction is squashed.
  3. **`load_use`:** `pc_write` = `ifid_write` = 0, `idex_bubble` = 1.
  4. **Otherwise:** `pc_write` = `ifid_write` = 1; all flush and bubble outputs are 0.
- `flush_pend` register:
  - Sets when `redirect_3` && `memory_stall`.
  - Clears on the first cycle with `memory_stall` = 0, which is the cycle it is applied.
  - A second redirect while it is pending is absorbed; the flush is still applied exactly once.
- The watchdog counts consecutive cycles with `memory_stall` = 1.
  - It saturates at `STALL_LIMIT`.
  - It clears to 0 on any cycle with `memory_stall` = 0.
  - `stall_timeout` sets on the edge where the count reaches `STALL_LIMIT` and stays set until `rst`.

## Timing
- All flush, stall, bubble and write-enable outputs are combinational from inputs and registered state, valid in the same cycle. There is no added latency.
- A held redirect is applied in the first cycle after `memory_stall` falls, with zero cycles of delay after release.
- A load-use hazard inserts exactly one bubble. On the next edge the load leaves ID/EX, so `load_use` deasserts unless a new load is present.
- Reset values: state = RUN, `flush_pend` = 0, watchdog count = 0, `stall_timeout` = 0, perf counters = 0. Combinational outputs follow their inputs during reset.
- If `rst` asserts mid-stall, the pending flush is discarded and the watchdog is cleared asynchronously.
- `redirect_3` and `load_use` in the same non-stall cycle: flush wins, and no bubble is issued.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - Adds three 32-bit wrap-around output counters:
    - `perf_stall_cycles`: cycles spent in MEM_WAIT.
    - `perf_bubbles`: cycles with `idex_bubble` = 1.
    - `perf_flushes`: cycles with `ifid_flush` = 1.
  - All three reset to 0.
- Undefined: the counter ports and logic are absent. All other behaviour is identical.

## Structure
- Shared package `hazard_pkg`:
  - FSM state encoding: RUN = 0, MEM_WAIT = 1.
  - `Mem` field bit positions: `MEM_READ_BIT` = 1, `MEM_WRITE_BIT` = 0.
  - The `STALL_LIMIT` default.
- Sub-module `stall_watchdog`: the saturating counter plus the sticky `stall_timeout` flag, parameterised by `STALL_LIMIT`.

## Test plan
- **Load-use bubble:** `Mem_2` = 2'b10, `Rd_2` = 5, `Rs1_1` = 5, `use_rs1_1` = 1 → one cycle of `idex_bubble` = 1 with `pc_write` = `ifid_write` = 0. Next cycle with `Mem_2` = 0 → all enables 1.
- **x0 excluded:** same as the load-use case but `Rd_2` = 0 → no bubble.
- **Redirect held across a stall:** pulse `redirect_3` while `DCache_stall` = 1 for 4 cycles → no flush during the stall. In the first cycle after release, `ifid_flush` = `idex_flush` = `pc_write` = 1, asserted exactly once.
- **Redirect beats load-use:** `redirect_3` = 1 and a load-use hazard in the same non-stall cycle → flushes asserted, `idex_bubble` = 0.
- **Watchdog:** `STALL_LIMIT` = 8, hold `ICache_stall` = 1 → `stall_timeout` rises after the 8th stall cycle and stays 1 after the stall releases, until `rst` pulses.
- **Perf counters (with `HAZARD_PERF_CNT_EN`):** 3 stall cycles, 2 bubbles, 1 flush → `perf_stall_cycles` = 3, `perf_bubbles` = 2, `perf_flushes` = 1. Asynchronous `rst` mid-stall clears all counters and `flush_pend`.
